// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI-slave register bank with RO mapping, sticky maskable interrupts; define SPI_BURST_EN for auto-increment bursts
module spi_reg_bank #(
    parameter int NUM_REGS = 32,
    parameter int DATA_BITS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0,
    parameter logic [6:0] INT_ADDR = 7'h13,
    parameter logic [6:0] INT_MASK_ADDR = 7'h18
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_cs0,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic miso_oe,
    output logic [NUM_REGS*DATA_BITS-1:0] regs_out,
    input  logic [NUM_REGS*DATA_BITS-1:0] regs_in,
    input  logic [DATA_BITS-1:0] int_in,
    output logic irq,
    output logic wr_stb,
    output logic rd_stb,
    output logic [6:0] reg_addr,
    output logic [DATA_BITS-1:0] wr_data
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] ARM = 2'd0;
    localparam logic [1:0] IDLE = 2'd1;
    localparam logic [1:0] CMD = 2'd2;
    localparam logic [1:0] DATA = 2'd3;
`ifdef SPI_BURST_EN
    localparam logic [6:0] ADDR_STEP = 7'd1;
`else
    localparam logic [6:0] ADDR_STEP = 7'd0;
`endif

    logic [1:0] state;
    logic [1:0] cs_s;
    logic [1:0] sck_s;
    logic [1:0] mosi_s;
    logic cs_d;
    logic sck_d;
    logic cs_rise;
    logic cs_fall;
    logic sck_rise;
    logic sck_fall;
    logic [7:0] bit_cnt;
    logic last;
    logic [DATA_BITS-2:0] sh_in;
    logic [DATA_BITS-1:0] rx_byte;
    logic rw;
    logic [6:0] cur_addr;
    logic [DATA_BITS-1:0] miso_sh;
    logic skip;
    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [DATA_BITS-1:0] int_status;
    logic [DATA_BITS-1:0] int_prev;
    logic [DATA_BITS-1:0] int_mask;
    logic [DATA_BITS-1:0] rd_val;
    logic [AW-1:0] idx;
    logic in_range;
    logic wr_ok;

    assign cs_rise = cs_s[1] & ~cs_d;
    assign cs_fall = ~cs_s[1] & cs_d;
    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;
    assign rx_byte = {sh_in, mosi_s[1]};
    assign last = (state == CMD) ? (bit_cnt == 8'd7) : (bit_cnt == 8'(DATA_BITS - 1));
    assign idx = reg_addr[AW-1:0];
    assign in_range = {1'b0, reg_addr} < 8'(NUM_REGS);
    assign wr_ok = in_range && !RO_MASK[idx] && (reg_addr != INT_ADDR);
    assign int_mask = regs[INT_MASK_ADDR[AW-1:0]];
    assign rd_val = !in_range ? DATA_BITS'(8'h99)
                  : (reg_addr == INT_ADDR) ? int_status
                  : RO_MASK[idx] ? regs_in[idx*DATA_BITS +: DATA_BITS]
                  : regs[idx];
    assign spi_miso = miso_oe ? miso_sh[DATA_BITS-1] : 1'bz;

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_out
            assign regs_out[i*DATA_BITS +: DATA_BITS] = regs[i];
        end
    endgenerate

    // Two-flop synchronisers plus previous-sample registers for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_s <= 2'b11;
            sck_s <= 2'b00;
            mosi_s <= 2'b00;
            cs_d <= 1'b1;
            sck_d <= 1'b0;
        end else begin
            cs_s <= {cs_s[0], spi_cs0};
            sck_s <= {sck_s[0], spi_clk};
            mosi_s <= {mosi_s[0], spi_mosi};
            cs_d <= cs_s[1];
            sck_d <= sck_s[1];
        end
    end

    // Frame FSM: command decode, byte assembly, address stepping and strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARM;
            bit_cnt <= '0;
            sh_in <= '0;
            rw <= 1'b0;
            cur_addr <= '0;
            reg_addr <= '0;
            wr_data <= '0;
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            if (cs_rise || (state == ARM && cs_s[1])) begin
                state <= IDLE;
            end else if (state == IDLE && cs_fall) begin
                state <= CMD;
                bit_cnt <= '0;
            end else if ((state == CMD || state == DATA) && sck_rise) begin
                sh_in <= rx_byte[DATA_BITS-2:0];
                bit_cnt <= last ? '0 : bit_cnt + 8'd1;
                if (last && state == CMD) begin
                    state <= DATA;
                    rw <= rx_byte[7];
                    cur_addr <= rx_byte[6:0];
                    reg_addr <= rx_byte[6:0];
                    rd_stb <= rx_byte[7];
                end else if (last) begin
                    cur_addr <= cur_addr + ADDR_STEP;
                    reg_addr <= rw ? cur_addr + ADDR_STEP : cur_addr;
                    rd_stb <= rw;
                    wr_stb <= !rw;
                    wr_data <= rw ? wr_data : rx_byte;
                end
            end
        end
    end

    // Shift-out register: load on fetch, skip the falling edge that follows a load
    always_ff @(posedge clk) begin
        if (reset || cs_rise) begin
            miso_sh <= '0;
            miso_oe <= 1'b0;
            skip <= 1'b0;
        end else if (rd_stb) begin
            miso_sh <= rd_val;
            miso_oe <= (state == DATA);
            skip <= 1'b1;
        end else if (sck_fall) begin
            miso_sh <= skip ? miso_sh : {miso_sh[DATA_BITS-2:0], 1'b0};
            skip <= 1'b0;
        end
    end

    // Register file write port; RO, out-of-range and interrupt-status writes are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (wr_stb && wr_ok) begin
            regs[idx] <= wr_data;
        end
    end

    // Sticky interrupt status: read of INT_ADDR clears, a simultaneous new edge wins
    always_ff @(posedge clk) begin
        int_prev <= int_in;
        if (reset) begin
            int_status <= '0;
            irq <= 1'b0;
        end else begin
            int_status <= ((rd_stb && reg_addr == INT_ADDR) ? '0 : int_status) | (int_in & ~int_prev);
            irq <= |(int_status & int_mask);
        end
    end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: SPI frames checked against a byte-level model through strobe and readback scoreboards
`timescale 1ns/1ps
module tb_spi_reg_bank;
    localparam int NR = 32;
    localparam int DB = 8;
    localparam logic [NR-1:0] RO = 32'h0000_0402;
    localparam logic [6:0] IA = 7'h13;
    localparam logic [6:0] MA = 7'h18;
`ifdef SPI_BURST_EN
    localparam int BURST = 1;
`else
    localparam int BURST = 0;
`endif
    localparam int HALF = 80;

    logic clk = 0;
    logic reset = 1;
    logic spi_cs0 = 1;
    logic spi_clk = 0;
    logic spi_mosi = 0;
    wire spi_miso;
    logic miso_oe, irq, wr_stb, rd_stb;
    logic [NR*DB-1:0] regs_out;
    logic [NR*DB-1:0] regs_in;
    logic [DB-1:0] int_in = 0;
    logic [DB-1:0] wr_data;
    logic [6:0] reg_addr;

    spi_reg_bank #(.NUM_REGS(NR), .DATA_BITS(DB), .RO_MASK(RO), .INT_ADDR(IA), .INT_MASK_ADDR(MA)) dut (
        .clk(clk), .reset(reset), .spi_cs0(spi_cs0), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .miso_oe(miso_oe), .regs_out(regs_out), .regs_in(regs_in),
        .int_in(int_in), .irq(irq), .wr_stb(wr_stb), .rd_stb(rd_stb), .reg_addr(reg_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] mdl [NR];
    logic [7:0] rin [NR];
    logic [7:0] ist;
    logic [14:0] exp_wr[$];
    logic [6:0] exp_rd[$];
    logic [7:0] exp_rdata[$];
    logic [7:0] tx[$];
    bit seen;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endfunction

    function automatic void unexpected(string nm, logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected", nm, act);
    endfunction

    function automatic logic [255:0] mdl_flat();
        logic [255:0] r = '0;
        for (int k = 0; k < NR; k++) r[k*8 +: 8] = mdl[k];
        return r;
    endfunction

    function automatic logic [7:0] rd_model(logic [6:0] a);
        int ai = int'(a);
        logic [7:0] v;
        if (ai >= NR) v = 8'h99;
        else if (a == IA) begin
            v = ist;
            ist = 8'h00;
        end else if (RO[ai]) v = rin[ai];
        else v = mdl[ai];
        return v;
    endfunction

    function automatic void model_frame();
        logic [6:0] a = tx[0][6:0];
        logic [7:0] v;
        if (tx[0][7]) begin
            for (int f = 0; f < tx.size(); f++) begin
                exp_rd.push_back(a);
                v = rd_model(a);
                if (f < tx.size() - 1) exp_rdata.push_back(v);
                a = a + 7'(BURST);
            end
        end else begin
            for (int j = 1; j < tx.size(); j++) begin
                exp_wr.push_back({a, tx[j]});
                if (int'(a) < NR && !RO[int'(a)] && a != IA) mdl[int'(a)] = tx[j];
                a = a + 7'(BURST);
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst wr_stb", wr_stb, 0);
        chk("rst rd_stb", rd_stb, 0);
        chk("rst irq", irq, 0);
        chk("rst miso_oe", miso_oe, 0);
        chk("rst reg_addr", reg_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst regs_out", regs_out, 0);
        reset = 0;
        for (int k = 0; k < NR; k++) mdl[k] = 8'h00;
        ist = 8'h00;
    endtask

    task automatic run_frame(input int last_bits, input int rst_bit);
        logic [7:0] rx = 0;
        int total = (tx.size() - 1) * 8 + last_bits;
        spi_cs0 = 0;
        #(HALF);
        for (int b = 0; b < total; b++) begin
            if (b == rst_bit) do_reset();
            spi_mosi = tx[b/8][7-(b%8)];
            #(HALF);
            rx = {rx[6:0], spi_miso};
            if (tx[0][7] && b == 8) chk("miso_oe in read", miso_oe, 1);
            spi_clk = 1;
            #(HALF);
            spi_clk = 0;
            if (tx[0][7] && b >= 8 && b % 8 == 7) begin
                if (exp_rdata.size() == 0) unexpected("miso byte", {24'h0, rx});
                else chk("miso byte", rx, exp_rdata.pop_front());
            end
        end
        #(HALF);
        spi_cs0 = 1;
        #(HALF*2);
    endtask

    task automatic settle_check();
        chk("regs_out", regs_out, mdl_flat());
        chk("irq", irq, |(ist & mdl[int'(MA)]));
        chk("miso_oe idle", miso_oe, 0);
        chk("wr queue drained", exp_wr.size(), 0);
        chk("rd queue drained", exp_rd.size(), 0);
        chk("rdata queue drained", exp_rdata.size(), 0);
    endtask

    task automatic send();
        model_frame();
        run_frame(8, -1);
        settle_check();
    endtask

    task automatic pulse_int(input logic [7:0] v);
        int_in = v;
        repeat (3) @(posedge clk);
        #1 int_in = 0;
        repeat (3) @(posedge clk);
        #1;
        ist = ist | v;
    endtask

    always @(negedge clk) begin
        if (wr_stb) begin
            if (exp_wr.size() == 0) unexpected("wr_stb", {17'h0, reg_addr, wr_data});
            else chk("wr_stb addr/data", {reg_addr, wr_data}, exp_wr.pop_front());
        end
        if (rd_stb) begin
            if (exp_rd.size() == 0) unexpected("rd_stb", {25'h0, reg_addr});
            else chk("rd_stb addr", reg_addr, exp_rd.pop_front());
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a;
        int nd;
        for (int k = 0; k < NR; k++) rin[k] = 8'($urandom);
        rin[1] = 8'h5C;
        for (int k = 0; k < NR; k++) regs_in[k*8 +: 8] = rin[k];
        for (int k = 0; k < NR; k++) mdl[k] = 8'h00;
        ist = 8'h00;
        repeat (2) @(posedge clk);
        do_reset();
        #(HALF*2);

        tx = {8'h00, 8'hA5};
        send();
        chk("reg0 after write", regs_out[7:0], 8'hA5);

        tx = {8'h02, 8'h11, 8'h22, 8'h33};
        send();
        chk("reg2 after burst frame", regs_out[23:16], BURST ? 8'h11 : 8'h33);

        tx = {8'h81, 8'h00};
        send();
        tx = {8'hFF, 8'h00};
        send();

        tx = {8'h18, 8'h01};
        send();
        pulse_int(8'h01);
        chk("irq after int edge", irq, 1);
        tx = {8'h93, 8'h00};
        send();

        pulse_int(8'h01);
        tx = {8'h93, 8'h00, 8'h00};
        repeat (3) exp_rd.push_back(IA);
        exp_rdata.push_back(8'h01);
        exp_rdata.push_back(8'h01);
        ist = 8'h00;
        seen = 0;
        fork
            run_frame(8, -1);
            begin
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    seen = rd_stb && reg_addr == IA;
                end
                chk("clear-cycle fetch seen", seen, 1);
                int_in[0] = 1;
            end
        join
        int_in = 0;
        repeat (3) @(posedge clk);
        #1;
        settle_check();

        tx = {8'h05, 8'hFF};
        run_frame(5, -1);
        settle_check();
        tx = {8'h05, 8'h3C};
        send();

        tx = {8'h06, 8'h77};
        run_frame(8, 11);
        settle_check();
        tx = {8'h06, 8'h3C};
        send();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: a = 7'($urandom_range(0, 127));
                1: a = ($urandom_range(0, 1) == 1) ? IA : MA;
                default: a = 7'($urandom_range(0, 40));
            endcase
            nd = $urandom_range(1, 3);
            tx = {{($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, a}};
            for (int j = 0; j < nd; j++) tx.push_back(8'($urandom));
            send();
            if ($urandom_range(0, 2) == 0) begin
                pulse_int(8'($urandom));
                settle_check();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI-slave register bank: the next generation of the SPI register interface, folding the SPI slave front end and the register file into one block with a generic register count and width. It adds burst (auto-increment) access, per-register read-only mapping, and a maskable sticky interrupt register. It sits between the Raspberry Pi SPI pins and the audio, FIR, EQ, SRAM and MPIO control logic.

## Interface
Parameters:
- NUM_REGS, 32: number of addressable registers, at addresses 0..NUM_REGS-1 (max 128).
- DATA_BITS, 8: register width; also the SPI data byte length.
- RO_MASK, 0: NUM_REGS-bit vector; bit i=1 makes address i read-only, with reads returning the regs_in slice.
- INT_ADDR, 7'h13: address of the interrupt status register (read-to-clear).
- INT_MASK_ADDR, 7'h18: address of the interrupt mask register (R/W).

Ports:
- clk  in  1  system clock; must be at least 16x spi_clk.
- reset  in  1  synchronous, active-high reset.
- spi_cs0  in  1  chip select, active low, asynchronous.
- spi_clk  in  1  SPI clock, mode 0, asynchronous.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out(tri)  1  serial data out; Z whenever miso_oe=0.
- miso_oe  out  1  MISO drive enable.
- regs_out  out  NUM_REGS*DATA_BITS  flat register contents; register i is at [i*DATA_BITS +: DATA_BITS].
- regs_in  in  NUM_REGS*DATA_BITS  read-back values for RO_MASK addresses.
- int_in  in  DATA_BITS  interrupt sources, rising-edge sensitive.
- irq  out  1  |(int_status & int_mask).
- wr_stb  out  1  one-clk pulse per completed write byte.
- rd_stb  out  1  one-clk pulse per read fetch.
- reg_addr  out  7  address of the current access.
- wr_data  out  DATA_BITS  data written; valid while wr_stb=1.

## Operation
- spi_cs0, spi_clk and spi_mosi each pass through a 2-FF synchroniser, followed by edge detect on spi_clk.
- FSM states and transitions:
  - ARM: the only state left by reset. Moves to IDLE once synchronised cs is observed high, so a reset mid-frame ignores the rest of that frame.
  - IDLE: cs falling edge -> CMD; bit counter cleared.
  - CMD: shifts 8 bits on rising edges. Bit 7 = R/W (1 = read), bits 6:0 = address. After the 8th bit -> DATA; a read also issues a fetch.
  - DATA: shifts DATA_BITS per byte.
  - A cs rising edge in any state -> IDLE. A partial byte is discarded: no strobe, no register change.
- Write:
  - At byte completion, wr_stb pulses with reg_addr/wr_data, and the register is updated.
  - Writes are ignored when the address is RO, out of range, or INT_ADDR; wr_stb still pulses.
- Read:
  - rd_stb pulses; the addressed value is loaded into the shift-out register.
  - The value is the register for a RW address, the regs_in slice for a RO address, int_status for INT_ADDR, and 8'h99 for an out-of-range address.
  - The MSB is driven at load. The register shifts on each detected spi_clk falling edge except the first one after a load.
  - Each read data byte completion triggers the next fetch.
- miso_oe=1 only in CMD/DATA of a read frame, from load onward.
- Address handling within a frame: the address is 7 bits and wraps 127 -> 0; see Configuration for per-byte behaviour.
- Interrupts:
  - int_status bit sets on a rising edge of int_in (the previous sample is held internally).
  - Reading INT_ADDR clears exactly the bits captured in the read value, one clk after rd_stb.
  - If a new edge lands on that clear cycle, the set wins.
- Reset: all registers and int_status = 0; int_mask = 0; wr_stb=rd_stb=irq=miso_oe=0; reg_addr=0; wr_data=0; spi_miso=Z.

## Timing
- spi_clk edge detection latency is 3 clk after the pin edge (2 sync + 1 edge register).
- Write: wr_stb is high on the clk after the final rising edge is detected; the regs_out update is visible on the following clk.
- Read: rd_stb is high on the same clk position as wr_stb; spi_miso shows the MSB one clk later. This is well before the next rising edge at the 16x clock ratio.
- irq is registered and updates 1 clk after an int_status or int_mask change.
- Back-to-back frames need cs high for at least 4 clk.

## Configuration
- SPI_BURST_EN defined: reg_addr increments after every data byte within a frame (writes and reads), with 7-bit wrap.
- SPI_BURST_EN undefined: reg_addr stays fixed for the whole frame, so repeated bytes hit the same register (streaming to SPI_TO_SRAM-style ports).

## Test plan
- Write 0x00 <- 0xA5: frame 0x00,0xA5 -> one wr_stb with reg_addr=0, wr_data=0xA5; regs_out[7:0]=0xA5.
- Burst (SPI_BURST_EN): frame 0x02,0x11,0x22,0x33 -> regs 2,3,4 = 0x11,0x22,0x33; three wr_stb. Without the macro: reg 2 = 0x33.
- Read with RO_MASK bit 1 set, regs_in slice 1 = 0x5C: frame 0x81,0x00 -> MISO returns 0x5C; address 0x7F returns 0x99.
- Interrupt: int_mask=0x01, pulse int_in[0] -> irq=1. Read INT_ADDR -> 0x01 returned; irq=0 after. An int_in[0] edge on the clear clk leaves the bit set.
- cs raised after 5 bits of a data byte -> no wr_stb, register unchanged, FSM in IDLE.
- reset asserted mid-frame -> all outputs at reset values; the remaining bits of that frame are ignored; the next frame writes correctly.
